sid_filter_mc: RTL and testbench
================================

Name: sid_filter_mc

Overview:
Time-multiplexed state-variable filter and volume stage serving CHANNELS independent SID instances, for example a dual-SID build, with one shared 16x16 multiply-add.
- A `start` pulse once per ~1 MHz SID tick sequences all channels in order.
- Per-channel vlp/vbp/vhp state lives in an internal state memory.
- Sits between the voice/mixer stage and the audio output/resampler.
- Adds over the single-channel filter: channel count parameter, start/busy/done handshake, post-reset state-clear sweep, overrun flag, optional saturation.

Parameters:
CHANNELS, 2, number of filter channels (1..8).
W0_BITS, 16, width of unsigned cutoff coefficient w0, scaled as 2^17*w0*T (16..18).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a full pass over all channels
ch_o  out  $clog2(CHANNELS) (min 1)  channel currently being read; inputs below must be valid for this channel
w0  in  W0_BITS  cutoff coefficient for channel ch_o
q_inv  in  9  1/Q scaled by 256
vi  in  24 signed  filter input sum for ch_o
vd  in  24 signed  direct-path sum incl. DC offset for ch_o
mode  in  3  [0]=LP, [1]=BP, [2]=HP to mixer
vol  in  4  master volume
busy  out  1  high during clear sweep or pass
done  out  1  one-cycle pulse at end of pass
overrun  out  1  sticky: start seen while busy; cleared only by reset
audio_valid  out  1  one-cycle strobe, audio_o/audio_ch valid
audio_ch  out  $clog2(CHANNELS) (min 1)  channel of audio_o
audio_o  out  24 signed  vol*amix result

Behaviour:
- Reset values: all outputs 0 except busy=1. FSM enters CLR.
- CLR: writes zero vlp/vbp/vhp to channel k at cycle k, for k=0..CHANNELS-1, then goes to IDLE and busy=0.
- start during CLR or any busy cycle: ignored, overrun<=1.
- FSM states: IDLE, CLR, RD, BP, LP, HP, MIX, WR. IDLE+start -> RD with ch_o=0.
- Per channel, 6 cycles:
  - RD: latch inputs, read state.
  - BP: vbp' = vbp + ((-w0*vhp[23:8]) >>> 9).
  - LP: vlp' = vlp + ((-w0*vbp[23:8]) >>> 9), using the old vbp.
  - HP: vhp' = (q_inv*vbp'[23:8]) - vlp' - vi.
  - MIX: amix = vd + sel(vlp', vbp', vhp') per mode; product {vol,4'b0}*amix[23:8].
  - WR: write state, audio_valid=1, audio_o=product[23:0], audio_ch=k.
- After WR: ch_o increments and the FSM returns to RD; at the last channel it goes to IDLE with done=1 in the WR cycle.
- Timing: start at cycle 0 -> channel k audio_valid at cycle 6k+6; pass length 6*CHANNELS cycles. Back-to-back start is accepted in the cycle after done.
- Arithmetic: products are 32-bit signed (w0 zero-extended); dv = {p[31], p[31:9]} for W0_BITS=16, widened accordingly for larger W0_BITS. Internal sums are 25 bits before narrowing to 24.
- Reset mid-pass: immediate abort; CLR sweep reruns, state is zeroed.

Optional Feature:
SID_FILTER_SAT_EN.
- Defined: every 24-bit state and amix narrowing saturates to [-2^23, 2^23-1].
- Undefined: two's-complement wrap (truncate to 24 bits), matching the single-channel filter.

Decomposition:
- Package sid additions: `sfmc_state_e` FSM enum; `sfmc_chstate_t` packed struct {vlp, vbp, vhp} of s24_t; `SFMC_STAGES = 6`.
- Function `sat24` (25->24 bits, honouring the macro) also goes in the package.
- One sub-module: `sid_filter_state_ram`, a CHANNELS-deep x 72-bit, 1R1W synchronous RAM inferred to BRAM.
- The multiplier reuses the existing `muladd`.

Test Plan:
- Reset release with CHANNELS=2: busy=1 for 2 cycles, then 0. A start issued in the first cycle is ignored and sets overrun=1.
- Pass with all inputs 0: audio_valid at cycles 6 and 12 with audio_o=0; done at cycle 12.
- ch0: mode=0, vd=24'h010000, vol=15; ch1: vol=0. Required: ch0 audio_o = 240*256 = 61440; ch1 audio_o = 0.
- Step: vi=-65536, w0=2048, q_inv=256, mode=LP; run 5 passes. Output must match a golden C model bit-exactly, and ch1 state must remain 0 (channel isolation).
- vi=-(2^23-1) and w0=max on a loop driving vbp past 2^23:
  - With SID_FILTER_SAT_EN: vbp clamps at 8388607.
  - Without: vbp wraps negative.
- rst_n asserted at cycle 8 of a pass: outputs go to reset values; after CLR, a fresh pass yields state from zero.

Source files
------------

// File: rtl/sid_filter_mc_pkg.sv
// Shared types and narrowing helper for the multi-channel SID filter.
// SID_FILTER_SAT_EN selects saturating (defined) or wrapping (undefined) narrowing.
package sid_filter_mc_pkg;

   typedef logic signed [23:0] s24_t;
   typedef logic signed [24:0] s25_t;

   typedef enum logic [2:0] {IDLE, CLR, RD, BP, LP, HP, MIX, WR} sfmc_state_e;

   typedef struct packed {
      s24_t vlp;
      s24_t vbp;
      s24_t vhp;
   } sfmc_chstate_t;

   localparam int unsigned SFMC_STAGES = 6;

   // Overflow shows up as the two top bits of the 25-bit sum disagreeing.
   function automatic s24_t sat24(input s25_t x);
`ifdef SID_FILTER_SAT_EN
      if (x[24] != x[23]) begin
         return x[24] ? 24'sh800000 : 24'sh7FFFFF;
      end
      return x[23:0];
`else
      return x[23:0];
`endif
   endfunction

endpackage

// File: rtl/sid_filter_mc_if.sv
// Channel-side input bus and audio/status outputs of sid_filter_mc.
interface sid_filter_mc_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned W0_BITS  = 16
) ();
   import sid_filter_mc_pkg::*;

   localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic               start;
   logic [CW-1:0]      ch_o;
   logic [W0_BITS-1:0] w0;
   logic [8:0]         q_inv;
   s24_t               vi;
   s24_t               vd;
   logic [2:0]         mode;
   logic [3:0]         vol;
   logic               busy;
   logic               done;
   logic               overrun;
   logic               audio_valid;
   logic [CW-1:0]      audio_ch;
   s24_t               audio_o;

   modport master (
      output start, w0, q_inv, vi, vd, mode, vol,
      input  ch_o, busy, done, overrun, audio_valid, audio_ch, audio_o
   );

   modport slave (
      input  start, w0, q_inv, vi, vd, mode, vol,
      output ch_o, busy, done, overrun, audio_valid, audio_ch, audio_o
   );
endinterface

// File: rtl/muladd.sv
// Signed multiply-add p = a*b + c; output width equals the full product width.
module muladd #(
   parameter int unsigned AW = 17,
   parameter int unsigned BW = 16,
   parameter int unsigned PW = AW + BW
) (
   input  logic signed [AW-1:0] i_a,
   input  logic signed [BW-1:0] i_b,
   input  logic signed [PW-1:0] i_c,
   output logic signed [PW-1:0] o_p
);
   logic signed [PW-1:0] w_a;
   logic signed [PW-1:0] w_b;

   assign w_a = PW'(i_a);
   assign w_b = PW'(i_b);
   assign o_p = w_a * w_b + i_c;
endmodule

// File: rtl/sid_filter_mc_state_ram.sv
// Per-channel {vlp, vbp, vhp} store: 1R1W synchronous RAM, registered read.
module sid_filter_state_ram
   import sid_filter_mc_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned AW    = 1
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  sfmc_chstate_t i_wdata,
   input  logic [AW-1:0] i_raddr,
   output sfmc_chstate_t o_rdata
);
   sfmc_chstate_t r_mem [DEPTH];
   sfmc_chstate_t r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/sid_filter_mc.sv
// Time-multiplexed SVF + volume stage for CHANNELS SID instances, one shared multiplier.
// Narrowing behaviour follows SID_FILTER_SAT_EN (see sid_filter_mc_pkg::sat24).
module sid_filter_mc
   import sid_filter_mc_pkg::*;
#(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned W0_BITS  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   sid_filter_mc_if.slave  bus
);
   localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int unsigned MW = W0_BITS + 1;
   localparam int unsigned PW = MW + 16;
   localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

   sfmc_state_e        r_state;
   logic [CW-1:0]      r_ch;
   logic [CW-1:0]      r_audio_ch;
   logic               r_busy;
   logic               r_done;
   logic               r_overrun;
   logic               r_audio_valid;
   s24_t               r_audio_o;
   logic [W0_BITS-1:0] r_w0;
   logic [8:0]         r_q_inv;
   s24_t               r_vi;
   s24_t               r_vd;
   logic [2:0]         r_mode;
   logic [3:0]         r_vol;
   s24_t               r_vlp;
   s24_t               r_vbp_old;
   s24_t               r_vbp;
   s24_t               r_vhp;

   sfmc_chstate_t        w_rd;
   sfmc_chstate_t        w_wr;
   logic                 w_we;
   logic signed [MW-1:0] w_neg_w0;
   logic signed [MW-1:0] w_ma;
   logic signed [15:0]   w_mb;
   logic signed [PW-1:0] w_mc;
   logic signed [PW-1:0] w_mp;
   s25_t                 w_dv;
   s25_t                 w_amix;
   logic signed [15:0]   w_amix16;
   s24_t                 w_bp_new;
   s24_t                 w_lp_new;
   s24_t                 w_hp_new;

   assign w_we = (r_state == CLR) || (r_state == WR);
   assign w_wr = (r_state == CLR) ? '0 : sfmc_chstate_t'({r_vlp, r_vbp, r_vhp});

   sid_filter_state_ram #(.DEPTH(CHANNELS), .AW(CW)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_ch),
      .i_wdata (w_wr),
      .i_raddr (r_ch),
      .o_rdata (w_rd)
   );

   assign w_neg_w0 = -$signed({1'b0, r_w0});

   always_comb begin
      w_amix = s25_t'(r_vd);
      if (r_mode[0]) w_amix = w_amix + s25_t'(r_vlp);
      if (r_mode[1]) w_amix = w_amix + s25_t'(r_vbp);
      if (r_mode[2]) w_amix = w_amix + s25_t'(r_vhp);
   end

   assign w_amix16 = 16'(sat24(w_amix) >>> 8);

   // One multiplier, operands steered by stage; HP folds "- vlp' - vi" into the adder.
   always_comb begin
      w_ma = '0;
      w_mb = '0;
      w_mc = '0;
      case (r_state)
         BP: begin
            w_ma = w_neg_w0;
            w_mb = 16'($signed(w_rd.vhp) >>> 8);
         end
         LP: begin
            w_ma = w_neg_w0;
            w_mb = 16'(r_vbp_old >>> 8);
         end
         HP: begin
            w_ma = $signed(MW'(r_q_inv));
            w_mb = 16'(r_vbp >>> 8);
            w_mc = -PW'(r_vlp) - PW'(r_vi);
         end
         MIX: begin
            w_ma = $signed(MW'({r_vol, 4'b0000}));
            w_mb = w_amix16;
         end
         default: ;
      endcase
   end

   muladd #(.AW(MW), .BW(16), .PW(PW)) u_mul (
      .i_a (w_ma),
      .i_b (w_mb),
      .i_c (w_mc),
      .o_p (w_mp)
   );

   assign w_dv     = s25_t'(w_mp >>> 9);
   assign w_bp_new = sat24(s25_t'($signed(w_rd.vbp)) + w_dv);
   assign w_lp_new = sat24(s25_t'(r_vlp) + w_dv);
   assign w_hp_new = sat24(s25_t'(w_mp));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= CLR;
         r_ch          <= '0;
         r_busy        <= 1'b1;
         r_done        <= 1'b0;
         r_overrun     <= 1'b0;
         r_audio_valid <= 1'b0;
         r_audio_ch    <= '0;
         r_audio_o     <= '0;
         r_w0          <= '0;
         r_q_inv       <= '0;
         r_vi          <= '0;
         r_vd          <= '0;
         r_mode        <= '0;
         r_vol         <= '0;
         r_vlp         <= '0;
         r_vbp_old     <= '0;
         r_vbp         <= '0;
         r_vhp         <= '0;
      end else begin
         r_done        <= 1'b0;
         r_audio_valid <= 1'b0;
         if (bus.start && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            CLR: begin
               if (r_ch == LAST) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_ch    <= '0;
               end else begin
                  r_ch <= r_ch + CW'(1);
               end
            end
            IDLE: begin
               if (bus.start) begin
                  r_state <= RD;
                  r_busy  <= 1'b1;
                  r_ch    <= '0;
               end
            end
            RD: begin
               r_w0    <= bus.w0;
               r_q_inv <= bus.q_inv;
               r_vi    <= bus.vi;
               r_vd    <= bus.vd;
               r_mode  <= bus.mode;
               r_vol   <= bus.vol;
               r_state <= BP;
            end
            BP: begin
               r_vlp     <= w_rd.vlp;
               r_vbp_old <= w_rd.vbp;
               r_vbp     <= w_bp_new;
               r_state   <= LP;
            end
            LP: begin
               r_vlp   <= w_lp_new;
               r_state <= HP;
            end
            HP: begin
               r_vhp   <= w_hp_new;
               r_state <= MIX;
            end
            MIX: begin
               r_audio_o     <= s24_t'(w_mp);
               r_audio_ch    <= r_ch;
               r_audio_valid <= 1'b1;
               r_done        <= (r_ch == LAST);
               r_state       <= WR;
            end
            WR: begin
               if (r_ch == LAST) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
                  r_ch    <= '0;
               end else begin
                  r_ch    <= r_ch + CW'(1);
                  r_state <= RD;
               end
            end
            default: r_state <= CLR;
         endcase
      end
   end

   assign bus.ch_o        = r_ch;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.overrun     = r_overrun;
   assign bus.audio_valid = r_audio_valid;
   assign bus.audio_ch    = r_audio_ch;
   assign bus.audio_o     = r_audio_o;
endmodule

// File: tb/tb_sid_filter_mc.sv
// Directed bench for sid_filter_mc: bit-exact filter model feeding an output scoreboard.
module tb_sid_filter_mc;
   localparam int CH = 2;
   localparam int WB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sid_filter_mc_if #(.CHANNELS(CH), .W0_BITS(WB)) bus ();

   sid_filter_mc #(.CHANNELS(CH), .W0_BITS(WB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [WB-1:0]      t_w0   [CH];
   logic [8:0]         t_q    [CH];
   logic signed [23:0] t_vi   [CH];
   logic signed [23:0] t_vd   [CH];
   logic [2:0]         t_mode [CH];
   logic [3:0]         t_vol  [CH];

   // Inputs follow ch_o, as the filter expects per-channel data on demand.
   assign bus.w0    = t_w0[bus.ch_o];
   assign bus.q_inv = t_q[bus.ch_o];
   assign bus.vi    = t_vi[bus.ch_o];
   assign bus.vd    = t_vd[bus.ch_o];
   assign bus.mode  = t_mode[bus.ch_o];
   assign bus.vol   = t_vol[bus.ch_o];

   typedef struct {
      int     ch;
      longint data;
      int     cyc;
   } exp_t;
   exp_t sbq[$];

   longint m_lp [CH];
   longint m_bp [CH];
   longint m_hp [CH];

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint wrapn(input longint x, input int n);
      longint m;
      longint y;
      m = longint'(1) << n;
      y = x & (m - 1);
      if (y >= (m >>> 1)) y = y - m;
      return y;
   endfunction

   function automatic longint narrow24(input longint x);
      longint y;
      y = wrapn(x, 25);
`ifdef SID_FILTER_SAT_EN
      if (y > 64'sd8388607) return 64'sd8388607;
      if (y < -64'sd8388608) return -64'sd8388608;
      return y;
`else
      return wrapn(y, 24);
`endif
   endfunction

   function automatic longint hi16(input longint x);
      return x >>> 8;
   endfunction

   task automatic model_channel(input int k, output longint audio);
      longint w0, q, vi, vd, vol, bp, lp, hp, amix;
      logic [2:0] md;
      w0 = longint'(t_w0[k]);
      q  = longint'(t_q[k]);
      vi = longint'(t_vi[k]);
      vd = longint'(t_vd[k]);
      vol = longint'(t_vol[k]);
      md = t_mode[k];
      bp = narrow24(m_bp[k] + ((-w0 * hi16(m_hp[k])) >>> 9));
      lp = narrow24(m_lp[k] + ((-w0 * hi16(m_bp[k])) >>> 9));
      hp = narrow24(q * hi16(bp) - lp - vi);
      amix = vd;
      if (md[0]) amix = amix + lp;
      if (md[1]) amix = amix + bp;
      if (md[2]) amix = amix + hp;
      amix = narrow24(amix);
      audio = wrapn(vol * 16 * hi16(amix), 24);
      m_bp[k] = bp;
      m_lp[k] = lp;
      m_hp[k] = hp;
   endtask

   task automatic set_ch(input int k, input int w0, input int q, input int vi, input int vd,
                         input int md, input int vol);
      t_w0[k]   = WB'(w0);
      t_q[k]    = 9'(q);
      t_vi[k]   = 24'(vi);
      t_vd[k]   = 24'(vd);
      t_mode[k] = 3'(md);
      t_vol[k]  = 4'(vol);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pass(output int s);
      longint a;
      s = cyc;
      bus.start = 1'b1;
      for (int k = 0; k < CH; k++) begin
         model_channel(k, a);
         sbq.push_back('{ch: k, data: a, cyc: s + 6 * k + 6});
      end
      tick();
      bus.start = 1'b0;
   endtask

   task automatic run_pass();
      int s;
      int d;
      logic got;
      got = 1'b0;
      d = -1;
      start_pass(s);
      for (int n = 0; n < 6 * CH + 16; n++) begin
         @(negedge clk);
         got = bus.done;
         d = cyc - s;
         tick();
         if (got) break;
      end
      chk("done_seen", got, 1);
      chk("done_cyc", d, 6 * CH);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.audio_valid) begin
         n_checks++;
         assert (sbq.size() > 0) else begin
            n_err++;
            $error("FAIL sb_unexpected observed ch=%0d data=%0d expected none", bus.audio_ch, bus.audio_o);
         end
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("audio_o", bus.audio_o, e.data);
            chk("audio_ch", bus.audio_ch, e.ch);
            chk("audio_cyc", cyc, e.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      bus.start = 1'b0;
      for (int k = 0; k < CH; k++) begin
         set_ch(k, 0, 0, 0, 0, 0, 0);
         m_lp[k] = 0;
         m_bp[k] = 0;
         m_hp[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;

      // Reset release: CLR sweep, start in first cycle is ignored
      rst_n = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      chk("rst_busy_c0", bus.busy, 1);
      chk("rst_overrun_c0", bus.overrun, 0);
      chk("rst_valid", bus.audio_valid, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_audio_o", bus.audio_o, 0);
      chk("rst_ch_o", bus.ch_o, 0);
      tick();
      bus.start = 1'b0;
      @(negedge clk);
      chk("clr_busy_c1", bus.busy, 1);
      chk("overrun_set", bus.overrun, 1);
      tick();
      @(negedge clk);
      chk("clr_busy_c2", bus.busy, 0);
      tick();

      // All-zero pass
      run_pass();

      // Volume path: ch0 vol=15 on DC, ch1 muted
      set_ch(0, 0, 0, 0, 24'h010000, 0, 15);
      set_ch(1, 0, 0, 0, 24'h010000, 0, 0);
      run_pass();

      // Step response, ch1 must stay silent (isolation)
      set_ch(0, 2048, 256, -65536, 0, 1, 15);
      set_ch(1, 2048, 256, 0, 0, 7, 15);
      repeat (5) run_pass();

      // Large drive pushing vbp beyond 24-bit range
      set_ch(0, 65535, 256, -8388607, 0, 2, 15);
      repeat (8) run_pass();

      // Reset in cycle 8 of a pass
      set_ch(0, 2048, 256, -65536, 0, 7, 15);
      start_pass(s);
      repeat (7) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.busy, 1);
      chk("abort_valid", bus.audio_valid, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_audio_o", bus.audio_o, 0);
      chk("abort_ch_o", bus.ch_o, 0);
      chk("abort_overrun", bus.overrun, 0);
      sbq.delete();
      for (int k = 0; k < CH; k++) begin
         m_lp[k] = 0;
         m_bp[k] = 0;
         m_hp[k] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      chk("reclr_idle", bus.busy, 0);
      tick();

      // Fresh passes from zeroed state, back-to-back
      run_pass();
      run_pass();
      chk("b2b_overrun", bus.overrun, 0);
      repeat (2) tick();
      chk("sb_empty", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
